gray_to_bin_pipe: RTL and testbench

//  Downstream consumer of the binary-to-Gray encoder stage. Accepts W-bit Gray

---
 rtl/gray_to_bin_pipe.sv | 163 ++++++++++++++++
 tb/tb_gray_to_bin_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_to_bin_pipe.sv
// gray_to_bin_pipe: two-stage valid/ready pipeline that turns W-bit Gray words
// back into binary.
//
// Optional feature macro: GRAY_STEP_CHECK_EN
//   defined   -> consecutive accepted words are checked for a legal Gray step
//                (at most one bit changes). Illegal steps are flagged on
//                out_step_err and counted in a saturating err_cnt.
//   undefined -> no checker logic is built. out_step_err and err_cnt are 0.
//
// Handshake: a transfer happens on a cycle where valid and ready are both 1.
// S2 loads when it is empty or its word is leaving (out_ready).
// S1 loads when it is empty or S2 is loading.
// in_ready is that S1 load condition, so it is combinational from out_ready
// and forced low while rst is high.
module gray_to_bin_pipe #(
   parameter int W     = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     in_gray,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     out_bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_step_err,
   output logic [CNT_W-1:0] err_cnt
);

   // Pipeline state
   logic         s1_v_q, s1_v_d;
   logic [W-1:0] s1_gray_q, s1_gray_d;
   logic         s2_v_q, s2_v_d;
   logic [W-1:0] s2_bin_q, s2_bin_d;

   // Handshake and datapath helpers
   logic         s1_load;
   logic         s2_load;
   logic         in_fire;
   logic         out_fire;
   logic [W-1:0] s1_bin;

   // Stage load conditions and transfer strobes
   always_comb begin
      s2_load  = !s2_v_q || out_ready;
      s1_load  = !s1_v_q || s2_load;
      in_ready = !rst && s1_load;
      in_fire  = in_valid && in_ready;
      out_fire = s2_v_q && out_ready;
   end

   // Gray to binary: prefix XOR from the MSB down, one cycle
   always_comb begin
      s1_bin        = '0;
      s1_bin[W-1]   = s1_gray_q[W-1];
      for (int i = W - 2; i >= 0; i--) begin
         s1_bin[i] = s1_bin[i+1] ^ s1_gray_q[i];
      end
   end

   // Next-state for both pipeline stages; stages hold while blocked
   always_comb begin
      s1_v_d    = s1_v_q;
      s1_gray_d = s1_gray_q;
      s2_v_d    = s2_v_q;
      s2_bin_d  = s2_bin_q;
      if (s1_load) begin
         s1_v_d = in_fire;
         if (in_fire) begin
            s1_gray_d = in_gray;
         end
      end
      if (s2_load) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            s2_bin_d = s1_bin;
         end
      end
   end

   // Pipeline registers; reset flushes any in-flight words
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q    <= 1'b0;
         s1_gray_q <= '0;
         s2_v_q    <= 1'b0;
         s2_bin_q  <= '0;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_gray_q <= s1_gray_d;
         s2_v_q    <= s2_v_d;
         s2_bin_q  <= s2_bin_d;
      end
   end

   assign out_bin   = s2_bin_q;
   assign out_valid = s2_v_q;

`ifdef GRAY_STEP_CHECK_EN
   // Step checker state
   logic [W-1:0]     prev_q, prev_d;
   logic             prev_v_q, prev_v_d;
   logic             s1_err_q, s1_err_d;
   logic             s2_err_q, s2_err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [W-1:0]     step_diff;
   logic             step_bad;

   // More than one differing bit means clearing the lowest set bit of the
   // difference still leaves something set. No prev word -> never illegal.
   always_comb begin
      step_diff = in_gray ^ prev_q;
      step_bad  = prev_v_q && ((step_diff & (step_diff - W'(1))) != '0);
   end

   // Error bit travels with its word; prev follows every accepted word
   always_comb begin
      prev_d    = prev_q;
      prev_v_d  = prev_v_q;
      s1_err_d  = s1_err_q;
      s2_err_d  = s2_err_q;
      err_cnt_d = err_cnt_q;
      if (in_fire) begin
         prev_d   = in_gray;
         prev_v_d = 1'b1;
      end
      if (s1_load) begin
         s1_err_d = in_fire && step_bad;
      end
      if (s2_load) begin
         s2_err_d = s1_v_q && s1_err_q;
      end
      if (out_fire && s2_err_q && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   // Checker registers
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q    <= '0;
         prev_v_q  <= 1'b0;
         s1_err_q  <= 1'b0;
         s2_err_q  <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         prev_q    <= prev_d;
         prev_v_q  <= prev_v_d;
         s1_err_q  <= s1_err_d;
         s2_err_q  <= s2_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign out_step_err = s2_err_q;
   assign err_cnt      = err_cnt_q;
`else
   assign out_step_err = 1'b0;
   assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_gray_to_bin_pipe.sv
// Directed bench for gray_to_bin_pipe (W=8, CNT_W=8). Expected values are
// hand-computed; step-error expectations depend on GRAY_STEP_CHECK_EN.
module tb_gray_to_bin_pipe;

   localparam int W     = 8;
   localparam int CNT_W = 8;

`ifdef GRAY_STEP_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic [W-1:0]     in_gray;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     out_bin;
   logic             out_valid;
   logic             out_ready;
   logic             out_step_err;
   logic [CNT_W-1:0] err_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   // Directed stream tables
   logic [W-1:0] vin  [16];
   logic [W-1:0] vexp [16];
   logic         verr [16];

   gray_to_bin_pipe #(.W(W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_gray      (in_gray),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_bin      (out_bin),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_step_err (out_step_err),
      .err_cnt      (err_cnt)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_gray  = '0;
      out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   // Feed vin[0..n-1] back to back with out_ready=1 and check each result
   // one cycle after acceptance (two edges after the word was presented).
   task automatic stream(input string tag, input int n);
      out_ready = 1'b1;
      for (int c = 0; c <= n; c++) begin
         if (c < n) begin
            in_gray  = vin[c];
            in_valid = 1'b1;
            #1;
            chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (c == 0) begin
            chk({tag, "_lat_valid0"}, 32'(out_valid), 32'd0);
         end else begin
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_bin"},   32'(out_bin),   32'(vexp[c-1]));
            chk({tag, "_err"},   32'(out_step_err), 32'(verr[c-1] & CHK));
         end
      end
      step();
      chk({tag, "_drained"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_gray   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;

      // Reset state
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_err_cnt",   32'(err_cnt),   32'd0);
      chk("rst_out_bin",   32'(out_bin),   32'd0);
      chk("rst_step_err",  32'(out_step_err), 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // Basic conversion, full throughput
      vin[0] = 8'h00; vexp[0] = 8'h00; verr[0] = 1'b0;
      vin[1] = 8'hDD; vexp[1] = 8'h96; verr[1] = 1'b1;
      vin[2] = 8'hFF; vexp[2] = 8'hAA; verr[2] = 1'b1;
      stream("conv", 3);
      chk("conv_err_cnt", 32'(err_cnt), 32'(CHK ? 2 : 0));

      // Legal steps and holds
      do_reset();
      vin[0] = 8'h00; vexp[0] = 8'h00; verr[0] = 1'b0;
      vin[1] = 8'h01; vexp[1] = 8'h01; verr[1] = 1'b0;
      vin[2] = 8'h03; vexp[2] = 8'h02; verr[2] = 1'b0;
      vin[3] = 8'h02; vexp[3] = 8'h03; verr[3] = 1'b0;
      vin[4] = 8'h02; vexp[4] = 8'h03; verr[4] = 1'b0;
      stream("legal", 5);
      chk("legal_err_cnt", 32'(err_cnt), 32'd0);

      // Illegal step, then saturation
      do_reset();
      vin[0] = 8'h02; vexp[0] = 8'h03; verr[0] = 1'b0;
      vin[1] = 8'h07; vexp[1] = 8'h05; verr[1] = 1'b1;
      stream("illegal", 2);
      chk("illegal_err_cnt", 32'(err_cnt), 32'(CHK));
      out_ready = 1'b1;
      for (int k = 0; k < 600; k++) begin
         in_gray  = k[0] ? 8'h07 : 8'h02;
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      step();
      chk("sat_err_cnt", 32'(err_cnt), 32'(CHK ? 255 : 0));

      // Back-pressure: 01..04 with out_ready low for 5 edges
      do_reset();
      out_ready = 1'b0;
      in_gray   = 8'h01;
      in_valid  = 1'b1;
      #1;
      chk("stall_rdy0", 32'(in_ready), 32'd1);
      step();
      in_gray = 8'h02;
      #1;
      chk("stall_rdy1", 32'(in_ready), 32'd1);
      step();
      in_gray = 8'h03;
      #1;
      chk("stall_rdy_low", 32'(in_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_valid",  32'(out_valid), 32'd1);
         chk("stall_bin",    32'(out_bin),   32'h01);
         chk("stall_err",    32'(out_step_err), 32'd0);
         chk("stall_rdy",    32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("stall_release_rdy", 32'(in_ready), 32'd1);
      step();
      chk("rel_bin1", 32'(out_bin), 32'h03);
      chk("rel_err1", 32'(out_step_err), 32'(CHK));
      in_gray = 8'h04;
      step();
      chk("rel_bin2", 32'(out_bin), 32'h02);
      chk("rel_err2", 32'(out_step_err), 32'd0);
      in_valid = 1'b0;
      step();
      chk("rel_bin3",   32'(out_bin),   32'h07);
      chk("rel_valid3", 32'(out_valid), 32'd1);
      chk("rel_err3",   32'(out_step_err), 32'(CHK));
      step();
      chk("rel_drained", 32'(out_valid), 32'd0);
      chk("rel_err_cnt", 32'(err_cnt), 32'(CHK ? 2 : 0));

      // Reset with words in flight
      out_ready = 1'b0;
      in_gray   = 8'h11;
      in_valid  = 1'b1;
      step();
      in_gray = 8'h33;
      step();
      chk("flush_pre_valid", 32'(out_valid), 32'd1);
      rst      = 1'b1;
      in_valid = 1'b0;
      step();
      chk("flush_valid_rst", 32'(out_valid), 32'd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      step();
      chk("flush_valid_a", 32'(out_valid), 32'd0);
      step();
      chk("flush_valid_b", 32'(out_valid), 32'd0);
      chk("flush_err_cnt", 32'(err_cnt), 32'd0);
      vin[0] = 8'hFF; vexp[0] = 8'hAA; verr[0] = 1'b0;
      stream("first_after_rst", 1);
      chk("first_err_cnt", 32'(err_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Absolute time bound
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
